// File: rtl/knn_sched_if.sv
// knn_sched_if -- signal bundle between the kNN scheduler and its environment.
//   RAM1 read port : RAM1_A, RAM1_OE (to RAM), RAM1_Q (from RAM)
//   RAM2 write port: RAM2_A, RAM2_D, RAM2_WE (to RAM)
//   MAN banks      : RAM1_Q_latch, wen, MAN_A_W, q_ld (to banks), res_idx (from min tree)
//   Control        : start (in), busy, done (out)
// master = scheduler side, slave = memories / banks / controller side.
interface knn_sched_if;
    logic        start;
    logic [23:0] RAM1_Q;
    logic [19:0] RAM1_A;
    logic        RAM1_OE;
    logic [19:0] RAM2_A;
    logic [23:0] RAM2_D;
    logic        RAM2_WE;
    logic [23:0] RAM1_Q_latch;
    logic [7:0]  wen;
    logic [2:0]  MAN_A_W;
    logic        q_ld;
    logic [5:0]  res_idx;
    logic        busy;
    logic        done;

    modport master (
        input  start, RAM1_Q, res_idx,
        output RAM1_A, RAM1_OE, RAM2_A, RAM2_D, RAM2_WE,
               RAM1_Q_latch, wen, MAN_A_W, q_ld, busy, done
    );

    modport slave (
        output start, RAM1_Q, res_idx,
        input  RAM1_A, RAM1_OE, RAM2_A, RAM2_D, RAM2_WE,
               RAM1_Q_latch, wen, MAN_A_W, q_ld, busy, done
    );
endinterface

// File: rtl/knn_sched.sv
// knn_sched -- sequences a kNN run: loads 64 reference points from RAM1 into
// eight MAN banks, then streams NUM_QUERY query points (RAM1 address 64+q)
// through the distance/min pipeline and writes each nearest index to RAM2[q].
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - knn_sched_if.master (RAM1 read, RAM2 write, MAN bank, start/busy/done)
module knn_sched #(
    parameter int unsigned NUM_QUERY = 1024,
    parameter int unsigned PIPE_LAT  = 3
) (
    input  logic            clk,
    input  logic            rst,
    knn_sched_if.master     bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD_REF, LOAD_Q, WAIT_PIPE, WRITE, DONE
    } state_t;

    localparam logic [19:0] Q_LAST    = 20'(NUM_QUERY - 1);
    localparam logic [3:0]  WAIT_LAST = 4'(PIPE_LAT - 1);
    localparam logic [6:0]  REF_LAST  = 7'd65;

    state_t      state, state_nx;
    logic [6:0]  ref_cnt;   // cycle index inside LOAD_REF, 0..65, stops at 65
    logic [5:0]  ref_t;     // reference slot whose data is in the latch this cycle
    logic        q_phase;   // LOAD_Q: 0 = address issue, 1 = data latch
    logic [3:0]  wait_cnt;
    logic [19:0] q;
    logic        oe_d;      // a read was issued last cycle, so RAM1_Q is valid now
    logic [23:0] q_latch;
    logic [19:0] ram2_a_hold;
    logic [23:0] ram2_d_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ref_cnt     <= '0;
            q_phase     <= 1'b0;
            wait_cnt    <= '0;
            q           <= '0;
            oe_d        <= 1'b0;
            q_latch     <= '0;
            ram2_a_hold <= '0;
            ram2_d_hold <= '0;
        end else begin
            state <= state_nx;
            oe_d  <= bus.RAM1_OE;
            if (oe_d)
                q_latch <= bus.RAM1_Q;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        ref_cnt <= '0;
                        q       <= '0;
                    end
                end
                LOAD_REF: begin
                    if (ref_cnt != REF_LAST)
                        ref_cnt <= ref_cnt + 7'd1;
                end
                LOAD_Q:    q_phase  <= ~q_phase;
                WAIT_PIPE: wait_cnt <= (wait_cnt == WAIT_LAST) ? '0 : wait_cnt + 4'd1;
                WRITE: begin
                    ram2_a_hold <= q;
                    ram2_d_hold <= {18'b0, bus.res_idx};
                    if (q != Q_LAST)
                        q <= q + 20'd1;
                end
                default: ;
            endcase
        end
    end

    // Reads are issued at ref_cnt = t and the bank write happens two cycles
    // later, so the slot being written is ref_cnt - 2 (mod 64 covers t=62,63).
    assign ref_t = ref_cnt[5:0] - 6'd2;

    always_comb begin
        state_nx    = state;
        bus.RAM1_A  = '0;
        bus.RAM1_OE = 1'b0;
        bus.RAM2_WE = 1'b0;
        bus.wen     = '0;
        bus.MAN_A_W = '0;
        bus.q_ld    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start)
                    state_nx = LOAD_REF;
            end
            LOAD_REF: begin
                if (!ref_cnt[6]) begin
                    bus.RAM1_OE = 1'b1;
                    bus.RAM1_A  = {14'b0, ref_cnt[5:0]};
                end
                if (ref_cnt >= 7'd2) begin
                    bus.wen     = 8'b0000_0001 << ref_t[5:3];
                    bus.MAN_A_W = ref_t[2:0];
                end
                if (ref_cnt == REF_LAST)
                    state_nx = LOAD_Q;
            end
            LOAD_Q: begin
                if (!q_phase) begin
                    bus.RAM1_OE = 1'b1;
                    bus.RAM1_A  = q + 20'd64;
                end else begin
                    state_nx = WAIT_PIPE;
                end
            end
            WAIT_PIPE: begin
                bus.q_ld = (wait_cnt == '0);
                if (wait_cnt == WAIT_LAST)
                    state_nx = WRITE;
            end
            WRITE: begin
                bus.RAM2_WE = 1'b1;
                state_nx    = (q == Q_LAST) ? DONE : LOAD_Q;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.RAM1_Q_latch = q_latch;
    // The nearest index is only valid during WRITE, so the write bus shows it
    // live in that cycle and replays the held copy afterwards.
    assign bus.RAM2_A = (state == WRITE) ? q : ram2_a_hold;
    assign bus.RAM2_D = (state == WRITE) ? {18'b0, bus.res_idx} : ram2_d_hold;
    assign bus.busy   = (state != IDLE) && (state != DONE);
    assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_knn_sched.sv
// tb_knn_sched -- scoreboard bench for knn_sched (NUM_QUERY=4 and NUM_QUERY=1).
module tb_knn_sched;
    localparam int K_RD  = 0;
    localparam int K_WEN = 1;
    localparam int K_QLD = 2;
    localparam int K_WR  = 3;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int d;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   qn  = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    ev_t  exp1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    knn_sched_if bus ();
    knn_sched_if bus1 ();

    knn_sched #(.NUM_QUERY(4), .PIPE_LAT(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    knn_sched #(.NUM_QUERY(1), .PIPE_LAT(3)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // RAM1 model: data = address, one cycle after the read is issued.
    // Min-tree model for the main DUT: result for the n-th query of a run is n+10.
    always @(posedge clk) begin
        if (bus.RAM1_OE)
            bus.RAM1_Q <= {4'b0, bus.RAM1_A};
        if (!bus.busy)
            qn <= 0;
        else if (bus.q_ld) begin
            bus.res_idx <= 6'(10 + qn);
            qn <= qn + 1;
        end
    end

    task automatic push(input int kind, input int cy, input int a, input int d, input int cut);
        ev_t e;
        if (cy <= cut) begin
            e.kind = kind; e.cyc = cy; e.a = a; e.d = d;
            exp_q.push_back(e);
        end
    endtask

    // Expected trace of a main-DUT run whose start is driven in cycle c;
    // events after cycle 'cut' are not expected (reset abort).
    task automatic gen_exp(input int c, input int cut);
        int t, b;
        for (int k = 0; k < 66; k++) begin
            if (k < 64)
                push(K_RD, c + 1 + k, k, 0, cut);
            if (k >= 2) begin
                t = k - 2;
                push(K_WEN, c + 1 + k, 1 << (t >> 3), ((t & 7) << 24) | t, cut);
            end
        end
        for (int qi = 0; qi < 4; qi++) begin
            b = c + 67 + 6 * qi;
            push(K_RD,  b,     64 + qi, 0, cut);
            push(K_QLD, b + 2, 0, 0, cut);
            push(K_WR,  b + 5, qi, qi + 10, cut);
        end
    endtask

    task automatic check_ev(input bit sel, input int kind, input int cy, input int a, input int d);
        ev_t   e;
        string nm;
        nm = sel ? "ev_dut1" : "ev_dut";
        checks++;
        if ((sel ? exp1_q.size() : exp_q.size()) == 0) begin
            errors++;
            $display("FAIL %s: got kind=%0d cyc=%0d a=0x%0h d=0x%0h, required no event",
                     nm, kind, cy, a, d);
        end else begin
            e = sel ? exp1_q.pop_front() : exp_q.pop_front();
            if (e.kind != kind || e.cyc != cy || e.a != a || e.d != d) begin
                errors++;
                $display("FAIL %s: got kind=%0d cyc=%0d a=0x%0h d=0x%0h, required kind=%0d cyc=%0d a=0x%0h d=0x%0h",
                         nm, kind, cy, a, d, e.kind, e.cyc, e.a, e.d);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (bus.RAM1_OE === 1'b1)
                check_ev(1'b0, K_RD, cyc, int'(bus.RAM1_A), 0);
            if (bus.wen !== 8'h00 && !$isunknown(bus.wen))
                check_ev(1'b0, K_WEN, cyc, int'(bus.wen), int'({bus.MAN_A_W, bus.RAM1_Q_latch}));
            if (bus.q_ld === 1'b1)
                check_ev(1'b0, K_QLD, cyc, 0, 0);
            if (bus.RAM2_WE === 1'b1)
                check_ev(1'b0, K_WR, cyc, int'(bus.RAM2_A), int'(bus.RAM2_D));
            if (bus1.RAM2_WE === 1'b1)
                check_ev(1'b1, K_WR, cyc, int'(bus1.RAM2_A), int'(bus1.RAM2_D));
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target)
            @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_RAM1_A"},  32'(bus.RAM1_A), 0);
        chk({tag, "_RAM1_OE"}, 32'(bus.RAM1_OE), 0);
        chk({tag, "_RAM2_A"},  32'(bus.RAM2_A), 0);
        chk({tag, "_RAM2_D"},  32'(bus.RAM2_D), 0);
        chk({tag, "_RAM2_WE"}, 32'(bus.RAM2_WE), 0);
        chk({tag, "_latch"},   32'(bus.RAM1_Q_latch), 0);
        chk({tag, "_wen"},     32'(bus.wen), 0);
        chk({tag, "_MAN_A_W"}, 32'(bus.MAN_A_W), 0);
        chk({tag, "_q_ld"},    32'(bus.q_ld), 0);
        chk({tag, "_busy"},    32'(bus.busy), 0);
        chk({tag, "_done"},    32'(bus.done), 0);
    endtask

    // Full run from IDLE/DONE; optionally pulses start while busy.
    task automatic full_run(input bit poke_busy);
        int c;
        c = cyc;
        gen_exp(c, 1 << 30);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (poke_busy) begin
            wait_until(c + 30);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            wait_until(c + 67);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_until(c + 90);
        chk("done_before_end", 32'(bus.done), 0);
        chk("busy_before_end", 32'(bus.busy), 1);
        @(negedge clk);
        chk("done_at_end", 32'(bus.done), 1);
        chk("busy_at_end", 32'(bus.busy), 0);
        wait_until(c + 96);
        chk("hold_RAM2_A", 32'(bus.RAM2_A), 3);
        chk("hold_RAM2_D", 32'(bus.RAM2_D), 13);
        chk("hold_done", 32'(bus.done), 1);
    endtask

    initial begin
        int   c;
        ev_t  e1;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus1.start = 1'b0;
        bus1.RAM1_Q  = '0;
        bus1.res_idx = 6'd37;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_reset("idle_hold");

        // Run A: reference load + 4-query stream, start pokes while busy;
        // the NUM_QUERY=1 instance runs alongside.
        c = cyc;
        e1.kind = K_WR; e1.cyc = c + 72; e1.a = 0; e1.d = 37;
        exp1_q.push_back(e1);
        bus1.start = 1'b1;
        fork
            full_run(1'b1);
            begin
                @(negedge clk);
                bus1.start = 1'b0;
                wait_until(c + 72);
                chk("dut1_done_before", 32'(bus1.done), 0);
                @(negedge clk);
                chk("dut1_done_after", 32'(bus1.done), 1);
                chk("dut1_hold_D", 32'(bus1.RAM2_D), 37);
            end
        join

        // Run B: restart from DONE, identical trace.
        full_run(1'b0);

        // Run C: reset during WAIT_PIPE of query 2.
        c = cyc;
        gen_exp(c, c + 82);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(c + 82);
        chk("midrun_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrun");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrun_idle_busy", 32'(bus.busy), 0);
        chk("midrun_queue", 32'(exp_q.size()), 0);

        // Run D: rerun from reference load after the abort.
        full_run(1'b0);

        repeat (4) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 0);
        chk("final_queue1", 32'(exp1_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
